if_fetch_unit: RTL and testbench

- Instruction Fetch stage proper. Sits directly upstream of the IF/ID pipeline register and supplies its pc_in / instruction_in.
- Owns the program counter and drives a multi-cycle instruction-memory handshake.
- Applies branch redirects coming from EXE.
- Buffers one returned instruction so that a downstream freeze never loses a fetch.

---
 rtl/if_fetch_unit_pkg.sv | 20 ++
 rtl/if_fetch_slot.sv | 98 +++++++++
 rtl/if_fetch_unit.sv | 161 ++++++++++++++++
 tb/tb_if_fetch_unit.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: default widths, reset PC,
// NOP encoding and the fetch FSM state encoding.
package if_fetch_unit_pkg;

    localparam int unsigned FETCH_ADDRESS_LEN = 32;
    localparam int unsigned FETCH_STATS_W     = 32;

    localparam logic [FETCH_ADDRESS_LEN-1:0] FETCH_RESET_PC  = '0;
    localparam logic [FETCH_ADDRESS_LEN-1:0] FETCH_NOP_INSTR = '0;

    // FETCH: request outstanding at pc
    // HOLD : returned instruction parked in the hold buffer, no request
    // DRAIN: redirect pending, waiting for the in-flight request to complete
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_fetch_slot.sv
// Two-entry skid: an output slot feeding the IF/ID register plus one hold
// buffer that catches a fetch returning while the slot cannot advance.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   flush           drop both entries; output goes invalid / NOP next cycle
//   out_ready       downstream captures the slot this cycle (~freeze)
//   in_valid        new entry offered (in_pc, in_data)
//   may_load_c      slot can take a new entry this cycle (combinational)
//   out_valid, out_pc, out_data   registered slot contents
// Callers must not offer in_valid while the hold buffer is occupied.
module if_fetch_slot
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned         DATA_W = FETCH_ADDRESS_LEN,
    parameter logic [DATA_W-1:0]   NOP    = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              out_ready,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_data,
    output logic              may_load_c,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_data
);

    logic              valid_q,     valid_d;
    logic [DATA_W-1:0] pc_q,        pc_d;
    logic [DATA_W-1:0] data_q,      data_d;
    logic              buf_valid_q, buf_valid_d;
    logic [DATA_W-1:0] buf_pc_q,    buf_pc_d;
    logic [DATA_W-1:0] buf_data_q,  buf_data_d;

    // Slot is free when empty or being consumed this cycle.
    assign may_load_c = ~valid_q | out_ready;

    // Slot / buffer update; the buffer always drains before new input.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        data_d      = data_q;
        buf_valid_d = buf_valid_q;
        buf_pc_d    = buf_pc_q;
        buf_data_d  = buf_data_q;

        if (flush) begin
            valid_d     = 1'b0;
            data_d      = NOP;
            buf_valid_d = 1'b0;
        end else if (buf_valid_q) begin
            if (may_load_c) begin
                valid_d     = 1'b1;
                pc_d        = buf_pc_q;
                data_d      = buf_data_q;
                buf_valid_d = 1'b0;
            end
        end else if (in_valid) begin
            if (may_load_c) begin
                valid_d = 1'b1;
                pc_d    = in_pc;
                data_d  = in_data;
            end else begin
                buf_valid_d = 1'b1;
                buf_pc_d    = in_pc;
                buf_data_d  = in_data;
            end
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
            data_d  = NOP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            data_q      <= NOP;
            buf_valid_q <= 1'b0;
            buf_pc_q    <= '0;
            buf_data_q  <= '0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            data_q      <= data_d;
            buf_valid_q <= buf_valid_d;
            buf_pc_q    <= buf_pc_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_pc    = pc_q;
    assign out_data  = data_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the multi-cycle instruction
// memory handshake, applies EXE branch redirects and presents one fetched
// instruction (pc+4, instruction) to the IF/ID register.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   freeze                         downstream stall
//   branch_taken, branch_addr      redirect request (flush beats freeze)
//   imem_req, imem_addr            memory request, address = pc
//   imem_rdata, imem_ready         returned instruction / accept strobe
//   fetch_valid, pc_out, instruction_out   fetched slot
// Optional: define IF_FETCH_STATS_EN to add fetch_count and stall_count.
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter int unsigned            ADDRESS_LEN = FETCH_ADDRESS_LEN,
    parameter logic [ADDRESS_LEN-1:0] RESET_PC    = ADDRESS_LEN'(FETCH_RESET_PC),
    parameter logic [ADDRESS_LEN-1:0] NOP_INSTR   = ADDRESS_LEN'(FETCH_NOP_INSTR)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   branch_taken,
    input  logic [ADDRESS_LEN-1:0] branch_addr,
    output logic                   imem_req,
    output logic [ADDRESS_LEN-1:0] imem_addr,
    input  logic [ADDRESS_LEN-1:0] imem_rdata,
    input  logic                   imem_ready,
    output logic                   fetch_valid,
    output logic [ADDRESS_LEN-1:0] pc_out,
    output logic [ADDRESS_LEN-1:0] instruction_out
`ifdef IF_FETCH_STATS_EN
    ,
    output logic [FETCH_STATS_W-1:0] fetch_count,
    output logic [FETCH_STATS_W-1:0] stall_count
`endif
);

    fetch_state_e             state_q, state_d;
    logic [ADDRESS_LEN-1:0]   pc_q,    pc_d;
    logic [ADDRESS_LEN-1:0]   redir_q, redir_d;
    logic                     req_q,   req_d;
    logic [ADDRESS_LEN-1:0]   pc_plus4;
    logic                     slot_in_valid;
    logic                     slot_may_load;

    assign pc_plus4 = pc_q + ADDRESS_LEN'(4);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    if (!imem_ready) state_d = DRAIN;
                end else if (imem_ready && !slot_may_load) begin
                    state_d = HOLD;
                end
            end
            DRAIN: if (imem_ready) state_d = FETCH;
            HOLD:  if (branch_taken || slot_may_load) state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    // PC, redirect register and slot-input control.
    always_comb begin
        pc_d          = pc_q;
        redir_d       = redir_q;
        slot_in_valid = 1'b0;
        unique case (state_q)
            FETCH: begin
                if (branch_taken) begin
                    // Ready data is discarded; otherwise keep pc stable and drain.
                    if (imem_ready) pc_d    = branch_addr;
                    else            redir_d = branch_addr;
                end else if (imem_ready) begin
                    pc_d          = pc_plus4;
                    slot_in_valid = 1'b1;
                end
            end
            DRAIN: begin
                // Latest redirect target wins, including one arriving this cycle.
                if (imem_ready)        pc_d    = branch_taken ? branch_addr : redir_q;
                else if (branch_taken) redir_d = branch_addr;
            end
            HOLD: begin
                if (branch_taken) pc_d = branch_addr;
            end
            default: ;
        endcase
        req_d = (state_d != HOLD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            redir_q <= '0;
            req_q   <= 1'b1;
        end else begin
            pc_q    <= pc_d;
            redir_q <= redir_d;
            req_q   <= req_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = pc_q;

    if_fetch_slot #(
        .DATA_W (ADDRESS_LEN),
        .NOP    (NOP_INSTR)
    ) u_slot (
        .clk        (clk),
        .rst        (rst),
        .flush      (branch_taken),
        .out_ready  (~freeze),
        .in_valid   (slot_in_valid),
        .in_pc      (pc_plus4),
        .in_data    (imem_rdata),
        .may_load_c (slot_may_load),
        .out_valid  (fetch_valid),
        .out_pc     (pc_out),
        .out_data   (instruction_out)
    );

`ifdef IF_FETCH_STATS_EN
    logic [FETCH_STATS_W-1:0] fetch_count_q, fetch_count_d;
    logic [FETCH_STATS_W-1:0] stall_count_q, stall_count_d;
    logic                     slot_load;
    logic                     stall_cycle;

    // A valid slot load comes from either fresh data or the hold buffer.
    assign slot_load   = ~branch_taken & slot_may_load & (slot_in_valid | (state_q == HOLD));
    assign stall_cycle = (req_q & ~imem_ready) | (state_q == HOLD);

    always_comb begin
        fetch_count_d = fetch_count_q + FETCH_STATS_W'(slot_load);
        stall_count_d = stall_count_q + FETCH_STATS_W'(stall_cycle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count_q <= '0;
            stall_count_q <= '0;
        end else begin
            fetch_count_q <= fetch_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign fetch_count = fetch_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: behavioural instruction memory with
// programmable latency, a second instance with a wrapping reset PC.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req,  imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic [31:0] imem_rdata, imem_rdata2;
    logic        imem_ready, imem_ready2;
    logic        fetch_valid, fetch_valid2;
    logic [31:0] pc_out, pc_out2;
    logic [31:0] instruction_out, instruction_out2;
`ifdef IF_FETCH_STATS_EN
    logic [31:0] fetch_count, stall_count, fetch_count2, stall_count2;
`endif

    int unsigned mem_lat;
    int unsigned wait_cnt;
    int          n_cmp;
    int          n_fail;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    if_fetch_unit dut (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .fetch_valid(fetch_valid), .pc_out(pc_out), .instruction_out(instruction_out)
`ifdef IF_FETCH_STATS_EN
        , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
    );

    if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .freeze(freeze),
        .branch_taken(branch_taken), .branch_addr(branch_addr),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .imem_ready(imem_ready2),
        .fetch_valid(fetch_valid2), .pc_out(pc_out2), .instruction_out(instruction_out2)
`ifdef IF_FETCH_STATS_EN
        , .fetch_count(fetch_count2), .stall_count(stall_count2)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers mem_lat cycles after a request first appears.
    always_ff @(posedge clk) begin
        if (rst || !imem_req || imem_ready) wait_cnt <= 0;
        else                                wait_cnt <= wait_cnt + 1;
    end
    assign imem_ready  = imem_req && (wait_cnt + 1 >= mem_lat);
    assign imem_rdata  = instr_of(imem_addr);
    assign imem_ready2 = imem_req2;
    assign imem_rdata2 = instr_of(imem_addr2);

    // Leaves the bench at a falling edge just after reset is released.
    task automatic do_reset(input int unsigned lat);
        @(negedge clk);
        mem_lat = lat; rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(1);
        n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", fetch_valid); end
        n_cmp++; if (pc_out !== 32'h0) begin n_fail++; $display("FAIL rst_pc_out: got %h want 0", pc_out); end
        n_cmp++; if (instruction_out !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", instruction_out); end
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
        n_cmp++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rst_req: got %b want 1", imem_req); end
    endtask

    task automatic test_zero_wait();
        do_reset(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL zw_valid[%0d]: got %b want 1", i, fetch_valid); end
            n_cmp++; if (pc_out !== 32'(4*(i+1))) begin n_fail++; $display("FAIL zw_pc[%0d]: got %h want %h", i, pc_out, 32'(4*(i+1))); end
            n_cmp++; if (instruction_out !== instr_of(32'(4*i))) begin n_fail++; $display("FAIL zw_instr[%0d]: got %h want %h", i, instruction_out, instr_of(32'(4*i))); end
            n_cmp++; if (imem_addr !== 32'(4*(i+1))) begin n_fail++; $display("FAIL zw_addr[%0d]: got %h want %h", i, imem_addr, 32'(4*(i+1))); end
        end
`ifdef IF_FETCH_STATS_EN
        n_cmp++; if (fetch_count !== 32'd4) begin n_fail++; $display("FAIL zw_fetch_count: got %0d want 4", fetch_count); end
        n_cmp++; if (stall_count !== 32'd0) begin n_fail++; $display("FAIL zw_stall_count: got %0d want 0", stall_count); end
`endif
    endtask

    task automatic test_latency();
        do_reset(3);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL lat_addr[%0d]: got %h want 0", i, imem_addr); end
            n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL lat_valid_lo[%0d]: got %b want 0", i, fetch_valid); end
        end
        @(negedge clk);
        n_cmp++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL lat_pulse: got %b want 1", fetch_valid); end
        n_cmp++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL lat_pc: got %h want 4", pc_out); end
        n_cmp++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL lat_next_addr: got %h want 4", imem_addr); end
`ifdef IF_FETCH_STATS_EN
        n_cmp++; if (stall_count !== 32'd2) begin n_fail++; $display("FAIL lat_stall_count: got %0d want 2", stall_count); end
`endif
        @(negedge clk);
        n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL lat_pulse_end: got %b want 0", fetch_valid); end
        n_cmp++; if (instruction_out !== 32'h0) begin n_fail++; $display("FAIL lat_nop: got %h want 0", instruction_out); end
    endtask

    task automatic test_freeze();
        do_reset(1);
        @(negedge clk);
        n_cmp++; if (pc_out !== 32'h4) begin n_fail++; $display("FAIL frz_first: got %h want 4", pc_out); end
        freeze = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_cmp++; if (pc_out !== 32'h4 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL frz_hold_pc[%0d]: got %h/%b want 4/1", k, pc_out, fetch_valid); end
            n_cmp++; if (instruction_out !== instr_of(32'h0)) begin n_fail++; $display("FAIL frz_hold_instr[%0d]: got %h want %h", k, instruction_out, instr_of(32'h0)); end
            n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL frz_req[%0d]: got %b want 0", k, imem_req); end
        end
        freeze = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++; if (pc_out !== 32'(8+4*k) || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL frz_seq_pc[%0d]: got %h/%b want %h/1", k, pc_out, fetch_valid, 32'(8+4*k)); end
            n_cmp++; if (instruction_out !== instr_of(32'(4+4*k))) begin n_fail++; $display("FAIL frz_seq_instr[%0d]: got %h want %h", k, instruction_out, instr_of(32'(4+4*k))); end
`ifdef IF_FETCH_STATS_EN
            if (k == 0) begin
                n_cmp++; if (stall_count !== 32'd4) begin n_fail++; $display("FAIL frz_stall_count: got %0d want 4", stall_count); end
            end
`endif
        end
    endtask

    task automatic test_branch_outstanding();
        do_reset(1);
        @(negedge clk);
        @(negedge clk);
        mem_lat = 3;
        n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL br_pre_addr: got %h want 8", imem_addr); end
        branch_taken = 1'b1; branch_addr = 32'h100;
        @(negedge clk);
        branch_taken = 1'b0;
        n_cmp++; if (fetch_valid !== 1'b0 || instruction_out !== 32'h0) begin n_fail++; $display("FAIL br_flush: got %b/%h want 0/0", fetch_valid, instruction_out); end
        n_cmp++; if (imem_addr !== 32'h8 || imem_req !== 1'b1) begin n_fail++; $display("FAIL br_drain_addr1: got %h/%b want 8/1", imem_addr, imem_req); end
        @(negedge clk);
        n_cmp++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL br_drain_addr2: got %h want 8", imem_addr); end
        @(negedge clk);
        n_cmp++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL br_target_addr: got %h want 100", imem_addr); end
        n_cmp++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL br_discard: got %b want 0", fetch_valid); end
        mem_lat = 1;
        @(negedge clk);
        n_cmp++; if (pc_out !== 32'h104 || fetch_valid !== 1'b1) begin n_fail++; $display("FAIL br_out_pc: got %h/%b want 104/1", pc_out, fetch_valid); end
        n_cmp++; if (instruction_out !== instr_of(32'h100)) begin n_fail++; $display("FAIL br_out_instr: got %h want %h", instruction_out, instr_of(32'h100)); end
    endtask

    task automatic test_branch_hold();
        do_reset(1);
        freeze = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL bh_in_hold: got %b want 0", imem_req); end
        branch_taken = 1'b1; branch_addr = 32'h200;
        @(negedge clk);
        n_cmp++; if (fetch_valid !== 1'b0 || instruction_out !== 32'h0) begin n_fail++; $display("FAIL bh_flush: got %b/%h want 0/0", fetch_valid, instruction_out); end
        n_cmp++; if (imem_addr !== 32'h200 || imem_req !== 1'b1) begin n_fail++; $display("FAIL bh_addr: got %h/%b want 200/1", imem_addr, imem_req); end
        branch_taken = 1'b0; freeze = 1'b0;
        @(negedge clk);
        n_cmp++; if (pc_out !== 32'h204 || instruction_out !== instr_of(32'h200)) begin n_fail++; $display("FAIL bh_next: got %h/%h want 204/%h", pc_out, instruction_out, instr_of(32'h200)); end
    endtask

    task automatic test_drain_latest();
        do_reset(3);
        branch_taken = 1'b1; branch_addr = 32'h40;
        @(negedge clk);
        branch_addr = 32'h80;
        n_cmp++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL dl_stable: got %h want 0", imem_addr); end
        @(negedge clk);
        branch_taken = 1'b0;
        @(negedge clk);
        n_cmp++; if (imem_addr !== 32'h80) begin n_fail++; $display("FAIL dl_latest: got %h want 80", imem_addr); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset(1);
        @(negedge clk);
        mem_lat = 3;
        n_cmp++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL rmw_pre: got %h want 4", imem_addr); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (imem_addr !== 32'h0 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_post: got %h/%b want 0/0", imem_addr, fetch_valid); end
        @(negedge clk);
        n_cmp++; if (imem_addr !== 32'h0 || fetch_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_wait: got %h/%b want 0/0", imem_addr, fetch_valid); end
    endtask

    task automatic test_wrap();
        do_reset(1);
        n_cmp++; if (imem_addr2 !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wr_reset_addr: got %h want fffffffc", imem_addr2); end
        @(negedge clk);
        n_cmp++; if (pc_out2 !== 32'h0 || fetch_valid2 !== 1'b1) begin n_fail++; $display("FAIL wr_pc_out: got %h/%b want 0/1", pc_out2, fetch_valid2); end
        n_cmp++; if (instruction_out2 !== instr_of(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wr_instr: got %h want %h", instruction_out2, instr_of(32'hFFFF_FFFC)); end
        n_cmp++; if (imem_addr2 !== 32'h0) begin n_fail++; $display("FAIL wr_addr: got %h want 0", imem_addr2); end
        @(negedge clk);
        n_cmp++; if (pc_out2 !== 32'h4) begin n_fail++; $display("FAIL wr_pc_out2: got %h want 4", pc_out2); end
`ifdef IF_FETCH_STATS_EN
        n_cmp++; if (fetch_count2 !== 32'd2 || stall_count2 !== 32'd0) begin n_fail++; $display("FAIL wr_counts: got %0d/%0d want 2/0", fetch_count2, stall_count2); end
`endif
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0; mem_lat = 1;
        test_reset();
        test_zero_wait();
        test_latency();
        test_freeze();
        test_branch_outstanding();
        test_branch_hold();
        test_drain_latest();
        test_reset_mid_wait();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
